// File: rtl/pgm_ddram_arbiter.sv
// rtl/pgm_ddram_arbiter.sv - DDRAM front-end: multi-channel 64-bit line reads with per-channel line buffers, plus loader writes
module pgm_ddram_arbiter #(
    parameter int NUM_CH  = 3,
    parameter int AW      = 29,
    parameter int RR_MODE = 1
) (
    input  logic                 fixed_50m_clk,
    input  logic                 reset_n,
    input  logic [NUM_CH-1:0]    ch_req,
    input  logic [NUM_CH*AW-1:0] ch_addr,
    output logic [NUM_CH-1:0]    ch_ack,
    output logic [NUM_CH*64-1:0] ch_data,
    input  logic                 ld_active,
    input  logic                 ld_we,
    input  logic [26:0]          ld_addr,
    input  logic [15:0]          ld_din,
    output logic                 ld_ready,
    output logic                 ddram_rd,
    output logic                 ddram_we,
    output logic [AW-1:0]        ddram_addr,
    output logic [63:0]          ddram_din,
    output logic [7:0]           ddram_be,
    input  logic [63:0]          ddram_dout,
    input  logic                 ddram_busy,
    input  logic                 ddram_dout_ready
);
    localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WRITE} state_t;

    state_t                 state_q;
    logic [GW-1:0]          grant_q;
    logic [GW-1:0]          last_grant_q;
    logic [NUM_CH-1:0]      ch_ack_q;
    logic [NUM_CH*64-1:0]   ch_data_q;
    logic [NUM_CH-1:0]      valid_q;
    logic [AW-1:0]          tag_q [NUM_CH];
    logic                   ld_ready_q;
    logic [23:0]            whr_addr_q;
    logic [15:0]            whr_din_q;
    logic [1:0]             whr_lane_q;
    logic                   rd_q;
    logic                   we_q;
    logic [AW-1:0]          addr_q;
    logic [63:0]            din_q;
    logic [7:0]             be_q;
    logic                   ld_active_q;
    logic                   clr_pend_q;

    logic [NUM_CH-1:0]      elig_d;
    logic [NUM_CH-1:0]      hit_d;
    logic [GW-1:0]          hit_idx_d;
    logic [GW-1:0]          gnt_d;
    logic [7:0]             lane_be_d;
    logic                   ld_rise_d;
    logic                   unused_addr_bit;

    assign unused_addr_bit = ld_addr[0];
    assign ld_rise_d       = ld_active & ~ld_active_q;
    // A channel whose ack is on the wire this cycle is still holding req; skip it.
    assign elig_d          = ch_req & ~ch_ack_q & {NUM_CH{~ld_active}};

    always_comb begin
        int idx;
        idx       = 0;
        hit_d     = '0;
        hit_idx_d = '0;
        gnt_d     = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            hit_d[i] = elig_d[i] && valid_q[i] && (tag_q[i] == ch_addr[i*AW +: AW]);
            if (hit_d[i]) hit_idx_d = GW'(i);
            if (RR_MODE == 0 && elig_d[i]) gnt_d = GW'(i);
        end
        // Round-robin: scan downward so the closest channel after last_grant wins.
        if (RR_MODE != 0) begin
            for (int k = NUM_CH; k >= 1; k--) begin
                idx = int'(last_grant_q) + k;
                if (idx >= NUM_CH) idx = idx - NUM_CH;
                if (elig_d[idx]) gnt_d = GW'(idx);
            end
        end
    end

    always_comb begin
        lane_be_d = 8'h03;
        case (whr_lane_q)
            2'd0: lane_be_d = 8'h03;
            2'd1: lane_be_d = 8'h0C;
            2'd2: lane_be_d = 8'h30;
            2'd3: lane_be_d = 8'hC0;
            default: lane_be_d = 8'h03;
        endcase
    end

    always_ff @(posedge fixed_50m_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(NUM_CH - 1);
            ch_ack_q     <= '0;
            ch_data_q    <= '0;
            valid_q      <= '0;
            for (int i = 0; i < NUM_CH; i++) tag_q[i] <= '0;
            ld_ready_q   <= 1'b1;
            whr_addr_q   <= '0;
            whr_din_q    <= '0;
            whr_lane_q   <= '0;
            rd_q         <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            din_q        <= '0;
            be_q         <= 8'hFF;
            ld_active_q  <= 1'b0;
            clr_pend_q   <= 1'b0;
        end else begin
            ld_active_q <= ld_active;
            ch_ack_q    <= '0;
            if (ld_rise_d) begin
                valid_q <= '0;
                if (state_q == S_ISSUE || state_q == S_WAIT) clr_pend_q <= 1'b1;
            end
            if (ld_we && ld_ready_q) begin
                whr_addr_q <= ld_addr[26:3];
                whr_lane_q <= ld_addr[2:1];
                whr_din_q  <= ld_din;
                ld_ready_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (!ld_ready_q) begin
                        we_q    <= 1'b1;
                        addr_q  <= AW'(whr_addr_q);
                        din_q   <= {4{whr_din_q}};
                        be_q    <= lane_be_d;
                        state_q <= S_WRITE;
                    end else if (|hit_d) begin
                        ch_ack_q[hit_idx_d] <= 1'b1;
                    end else if (|elig_d) begin
                        grant_q <= gnt_d;
                        addr_q  <= ch_addr[int'(gnt_d)*AW +: AW];
                        rd_q    <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!ddram_busy) begin
                        rd_q    <= 1'b0;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (ddram_dout_ready) begin
                        ch_data_q[int'(grant_q)*64 +: 64] <= ddram_dout;
                        tag_q[grant_q]    <= addr_q;
                        // A loader start seen during the read leaves the fresh line invalid.
                        valid_q[grant_q]  <= !(clr_pend_q || ld_rise_d);
                        ch_ack_q[grant_q] <= 1'b1;
                        last_grant_q      <= grant_q;
                        clr_pend_q        <= 1'b0;
                        state_q           <= S_IDLE;
                    end
                end
                S_WRITE: begin
                    if (!ddram_busy) begin
                        we_q       <= 1'b0;
                        valid_q    <= '0;
                        ld_ready_q <= 1'b1;
                        state_q    <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ch_ack     = ch_ack_q;
    assign ch_data    = ch_data_q;
    assign ld_ready   = ld_ready_q;
    assign ddram_rd   = rd_q;
    assign ddram_we   = we_q;
    assign ddram_addr = addr_q;
    assign ddram_din  = din_q;
    assign ddram_be   = be_q;
endmodule
